// File: rtl/multiword_adder_seq.sv
// ---------------------------------------------------------------------------
// multiword_adder_seq
//   Sequential N-bit adder/subtractor (N = 16*WORDS). The operands are
//   captured once, then one 16-bit slice is added per cycle, LSB slice
//   first, through a single shared 16-bit carry-lookahead adder. The result
//   and its flags are presented with a valid/ready handshake.
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   IN_VALID   in   operand request valid
//   IN_READY   out  operands can be accepted (idle only)
//   X, Y       in   N-bit operands
//   C_in       in   carry-in for addition (ignored when SUB=1)
//   SUB        in   0: X+Y+C_in, 1: X-Y
//   OUT_VALID  out  result valid
//   OUT_READY  in   consumer takes the result
//   S          out  N-bit sum/difference
//   C_out      out  carry out of the MSB (subtract: 1 = no borrow)
//   V          out  signed overflow
//   Z          out  result is zero
// ---------------------------------------------------------------------------

// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead
// level across the groups. c15_o (carry into bit 15) is exported so the
// caller can form signed overflow on the top slice.
module cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c15_o,
    output logic        c_o
);
    logic [15:0] p, g;
    logic [16:0] c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    always_comb begin
        p  = a_i ^ b_i;
        g  = a_i & b_i;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = c_i;
        gc[1] = gg[0] | (gp[0] & gc[0]);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & gc[0]);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        c[16] = gc[4];
        s_o   = p ^ c[15:0];
        c15_o = c[15];
        c_o   = c[16];
    end
endmodule

module multiword_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [16*WORDS-1:0]   X,
    input  logic [16*WORDS-1:0]   Y,
    input  logic                  C_in,
    input  logic                  SUB,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [16*WORDS-1:0]   S,
    output logic                  C_out,
    output logic                  V,
    output logic                  Z
);
    localparam int N     = 16 * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [N-1:0]     x_q, y_q, s_q;
    logic             cout_q, v_q, z_q;
    logic             in_ready_q, out_valid_q;

    logic [15:0]      a_sl, b_sl, sum_sl;
    logic             c15_sl, cout_sl;
    logic [N-1:0]     s_d;

    // Slice base is idx*16, formed by concatenation to keep the index narrow.
    always_comb begin
        a_sl = x_q[{idx_q, 4'b0000} +: 16];
        b_sl = y_q[{idx_q, 4'b0000} +: 16];
        s_d  = s_q;
        s_d[{idx_q, 4'b0000} +: 16] = sum_sl;
    end

    cla16 u_cla (
        .a_i   (a_sl),
        .b_i   (b_sl),
        .c_i   (carry_q),
        .s_o   (sum_sl),
        .c15_o (c15_sl),
        .c_o   (cout_sl)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID && in_ready_q) begin
                        // Subtraction is X + ~Y + 1: invert Y once here and
                        // seed the carry with 1, so CALC only ever adds.
                        x_q        <= X;
                        y_q        <= Y ^ {N{SUB}};
                        carry_q    <= SUB | C_in;
                        idx_q      <= '0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    s_q     <= s_d;
                    carry_q <= cout_sl;
                    if (idx_q == LAST) begin
                        // Top slice: its carries are those of bits N-2/N-1.
                        cout_q      <= cout_sl;
                        v_q         <= c15_sl ^ cout_sl;
                        z_q         <= (s_d == '0);
                        idx_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign S         = s_q;
    assign C_out     = cout_q;
    assign V         = v_q;
    assign Z         = z_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
module tb_multiword_adder_seq;
    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [N-1:0] X = '0;
    logic [N-1:0] Y = '0;
    logic         C_in = 1'b0;
    logic         SUB = 1'b0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [N-1:0] S;
    logic         C_out, V, Z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    multiword_adder_seq #(.WORDS(WORDS)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .X(X), .Y(Y), .C_in(C_in), .SUB(SUB), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .S(S), .C_out(C_out), .V(V), .Z(Z)
    );

    // Reference: whole-word arithmetic with one extra bit for the carry.
    function automatic void model(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic cin, input logic sub,
                                  output logic [N-1:0] s, output logic c,
                                  output logic v, output logic z);
        logic [N:0] full;
        if (sub) full = {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
        else     full = {1'b0, x} + {1'b0, y} + (N+1)'(cin);
        s = full[N-1:0];
        c = full[N];
        if (sub) v = (x[N-1] != y[N-1]) && (s[N-1] != x[N-1]);
        else     v = (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
        z = (s == '0);
    endfunction

    // Drive one operation and leave the DUT in DONE; returns the observed
    // result and the cycle count from accept edge to OUT_VALID (-1 = none).
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic cin, input logic sub,
                          output logic [N-1:0] s, output logic c,
                          output logic v, output logic z, output int lat);
        int w;
        w = 0;
        while (!IN_READY && w < 20) begin
            @(posedge CLK); #1;
            w++;
        end
        X = x; Y = y; C_in = cin; SUB = sub; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        // Inputs change after accept; result must not depend on them.
        IN_VALID = 1'($urandom_range(0, 1));
        X = {$urandom, $urandom}; Y = {$urandom, $urandom};
        C_in = 1'($urandom_range(0, 1)); SUB = 1'($urandom_range(0, 1));
        lat = -1;
        for (int k = 1; k <= WORDS + 2; k++) begin
            OUT_READY = (k < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge CLK); #1;
            if (OUT_VALID) begin
                lat = k;
                break;
            end
        end
        OUT_READY = 1'b0;
        s = S; c = C_out; v = V; z = Z;
    endtask

    task automatic release_out();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        n_checks++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
        n_checks++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
        n_checks++;
        if ({S, C_out, V, Z} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got S=%h C=%b V=%b Z=%b want all 0", S, C_out, V, Z);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_directed();
        logic [N-1:0] vx[4], vy[4], es[4];
        logic         vc[4], vs[4], ec[4], ev[4], ez[4];
        logic [N-1:0] s;
        logic         c, v, z;
        int           lat;
        vx[0] = 64'hFFFF_FFFF_FFFF_FFFF; vy[0] = 64'd1; vc[0] = 0; vs[0] = 0;
        es[0] = 64'd0;                   ec[0] = 1; ev[0] = 0; ez[0] = 1;
        vx[1] = 64'd5; vy[1] = 64'd7; vc[1] = 1; vs[1] = 1;
        es[1] = 64'hFFFF_FFFF_FFFF_FFFE; ec[1] = 0; ev[1] = 0; ez[1] = 0;
        vx[2] = 64'h7FFF_FFFF_FFFF_FFFF; vy[2] = 64'd1; vc[2] = 0; vs[2] = 0;
        es[2] = 64'h8000_0000_0000_0000; ec[2] = 0; ev[2] = 1; ez[2] = 0;
        vx[3] = 64'h0000_0000_FFFF_FFFF; vy[3] = 64'd1; vc[3] = 1; vs[3] = 0;
        es[3] = 64'h0000_0001_0000_0001; ec[3] = 0; ev[3] = 0; ez[3] = 0;
        for (int i = 0; i < 4; i++) begin
            run_op(vx[i], vy[i], vc[i], vs[i], s, c, v, z, lat);
            n_checks++;
            if (lat !== WORDS) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, WORDS); end
            n_checks++;
            if (s !== es[i]) begin n_fail++; $display("FAIL dir%0d_S got %h want %h", i, s, es[i]); end
            n_checks++;
            if ({c, v, z} !== {ec[i], ev[i], ez[i]}) begin
                n_fail++; $display("FAIL dir%0d_flags got C=%b V=%b Z=%b want C=%b V=%b Z=%b",
                                   i, c, v, z, ec[i], ev[i], ez[i]);
            end
            release_out();
            n_checks++;
            if ({IN_READY, OUT_VALID} !== 2'b10) begin
                n_fail++; $display("FAIL dir%0d_release got rdy=%b vld=%b want rdy=1 vld=0", i, IN_READY, OUT_VALID);
            end
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] x, y, s, es;
        logic         c, v, z, ec, ev, ez;
        int           lat;
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        model(x, y, 1'b1, 1'b0, es, ec, ev, ez);
        run_op(x, y, 1'b1, 1'b0, s, c, v, z, lat);
        n_checks++;
        if ({s, c, v, z} !== {es, ec, ev, ez}) begin
            n_fail++; $display("FAIL hold_result got %h/%b%b%b want %h/%b%b%b", s, c, v, z, es, ec, ev, ez);
        end
        for (int k = 0; k < 10; k++) begin
            IN_VALID = 1'($urandom_range(0, 1));
            X = {$urandom, $urandom}; Y = {$urandom, $urandom};
            OUT_READY = 1'b0;
            @(posedge CLK); #1;
            n_checks++;
            if ({S, C_out, V, Z, IN_READY, OUT_VALID} !== {es, ec, ev, ez, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL hold_cycle%0d got S=%h C=%b V=%b Z=%b rdy=%b vld=%b want S=%h rdy=0 vld=1",
                                   k, S, C_out, V, Z, IN_READY, OUT_VALID, es);
            end
        end
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({IN_READY, OUT_VALID, S} !== {1'b1, 1'b0, es}) begin
            n_fail++; $display("FAIL hold_exit got rdy=%b vld=%b S=%h want rdy=1 vld=0 S=%h", IN_READY, OUT_VALID, S, es);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [N-1:0] x, y, s, es;
        logic         c, v, z, ec, ev, ez;
        int           lat, seen;
        X = 64'h1234_5678_9ABC_DEF0; Y = 64'd1; C_in = 1'b0; SUB = 1'b0;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        n_checks++;
        if (S[15:0] !== 16'hDEF1) begin n_fail++; $display("FAIL areset_pre_slice0 got %h want def1", S[15:0]); end
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({S, C_out, V, Z, IN_READY, OUT_VALID} !== {64'd0, 3'b000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL areset_immediate got S=%h C=%b V=%b Z=%b rdy=%b vld=%b want zero rdy=1 vld=0",
                               S, C_out, V, Z, IN_READY, OUT_VALID);
        end
        @(posedge CLK); #3;
        RST_N = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen = 1;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL areset_discard got out_valid=1 want never"); end
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        model(x, y, 1'b0, 1'b1, es, ec, ev, ez);
        run_op(x, y, 1'b0, 1'b1, s, c, v, z, lat);
        n_checks++;
        if ({s, c, v, z} !== {es, ec, ev, ez} || lat != WORDS) begin
            n_fail++; $display("FAIL areset_after got %h/%b%b%b lat=%0d want %h/%b%b%b lat=%0d",
                               s, c, v, z, lat, es, ec, ev, ez, WORDS);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [N-1:0] x, y, s, es;
        logic         cin, sub, c, v, z, ec, ev, ez;
        int           lat;
        for (int i = 0; i < 24; i++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: x = '1;
                1: y = '0;
                2: begin x = 64'h8000_0000_0000_0000; y = x; end
                3: begin x[31:0] = 32'hFFFF_FFFF; y[31:0] = 32'h0000_0001; end
                default: ;
            endcase
            if (i % 7 == 6) y = x;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            model(x, y, cin, sub, es, ec, ev, ez);
            run_op(x, y, cin, sub, s, c, v, z, lat);
            n_checks++;
            if ({s, c, v, z} !== {es, ec, ev, ez} || lat != WORDS) begin
                n_fail++; $display("FAIL rand%0d x=%h y=%h ci=%b sub=%b got %h/%b%b%b lat=%0d want %h/%b%b%b lat=%0d",
                                   i, x, y, cin, sub, s, c, v, z, lat, es, ec, ev, ez, WORDS);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiword_adder_seq.md
MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

Interface
- REQ-001: Parameter WORDS, default 4: number of 16-bit slices; operand width N = 16*WORDS; legal range 2..8.
- REQ-002: CLK  in  1  single clock; all state updates on rising edge.
- REQ-003: RST_N  in  1  reset, asynchronous, active-low.
- REQ-004: IN_VALID  in  1  operand request valid.
- REQ-005: IN_READY  out  1  block can accept operands (high only in IDLE).
- REQ-006: X  in  N  operand A.
- REQ-007: Y  in  N  operand B.
- REQ-008: C_in  in  1  carry-in; used only when SUB=0.
- REQ-009: SUB  in  1  0 = X+Y+C_in; 1 = X-Y (X + ~Y + 1).
- REQ-010: OUT_VALID  out  1  result valid.
- REQ-011: OUT_READY  in  1  consumer accepts result.
- REQ-012: S  out  N  registered sum/difference.
- REQ-013: C_out  out  1  carry out of bit N-1 (for SUB=1: 1 = no borrow).
- REQ-014: V  out  1  two's-complement signed overflow.
- REQ-015: Z  out  1  S equals zero.

Function
- REQ-016: Block SHALL compute the N-bit result one 16-bit slice per cycle, using a single 16-bit carry-lookahead adder instance, slice 0 (LSBs) first.
- REQ-017: FSM states SHALL be IDLE, CALC, DONE; IN_READY = (state==IDLE); OUT_VALID = (state==DONE).
- REQ-018: IDLE: on IN_VALID&&IN_READY, SHALL register X, Y^{N{SUB}}, SUB; carry register <= SUB ? 1 : C_in; slice index <= 0; next state CALC.
- REQ-019: X, Y, C_in, SUB SHALL be sampled only at the accept edge; later changes on those inputs SHALL have no effect on the result.
- REQ-020: CALC: each cycle SHALL add slice[idx] of the registered operands with the carry register, write the 16-bit sum into S[16*idx+15:16*idx], load the slice carry-out into the carry register, increment idx.
- REQ-021: When idx==WORDS-1 in CALC, after the write SHALL go to DONE, latch C_out from slice carry-out, V = carry into bit N-1 XOR carry out of bit N-1, Z = (S==0) over the complete result.
- REQ-022: Latency: OUT_VALID SHALL rise exactly WORDS cycles after the accept edge.
- REQ-023: DONE: S, C_out, V, Z SHALL hold stable while OUT_READY=0; IN_VALID SHALL be ignored.
- REQ-024: DONE with OUT_READY=1: next state IDLE; OUT_VALID falls, IN_READY rises on same edge; no same-cycle accept of new operands (max throughput one op per WORDS+2 cycles).
- REQ-025: S, C_out, V, Z SHALL not change except by REQ-020/021 writes; partial S slices during CALC are not valid until OUT_VALID.
- REQ-026: OUT_READY asserted outside DONE SHALL have no effect.

Reset
- REQ-027: RST_N low SHALL immediately (asynchronously) force state IDLE, idx=0, carry register=0, S=0, C_out=0, V=0, Z=0, OUT_VALID=0, IN_READY=1.
- REQ-028: Reset asserted mid-CALC or in DONE SHALL discard the operation; no result is ever presented for it.
- REQ-029: First accept SHALL be possible on the first rising edge after RST_N deasserts.

Verification (WORDS=4)
- REQ-030: X=0xFFFF_FFFF_FFFF_FFFF, Y=1, C_in=0, SUB=0 -> S=0, C_out=1, Z=1, V=0; OUT_VALID exactly 4 cycles after accept.
- REQ-031: X=5, Y=7, SUB=1, C_in=1 (ignored) -> S=0xFFFF_FFFF_FFFF_FFFE, C_out=0, V=0, Z=0.
- REQ-032: X=0x7FFF_FFFF_FFFF_FFFF, Y=1, SUB=0, C_in=0 -> S=0x8000_0000_0000_0000, V=1, C_out=0.
- REQ-033: X=0x0000_0000_FFFF_FFFF, Y=1, C_in=1 -> S=0x0000_0001_0000_0001 (carry crosses slices 0->1->2 correctly).
- REQ-034: Hold OUT_READY=0 for 10 cycles in DONE while toggling IN_VALID, X, Y -> S/C_out/V/Z stable, IN_READY=0, no new accept; then OUT_READY=1 -> IDLE next edge.
- REQ-035: Drop RST_N during CALC at idx=2 -> outputs zero and IN_READY=1 without a clock edge; next operation after release computes correctly.
